tone_sequencer: RTL and testbench

- Note-selection stage directly upstream of the tone organ's clock divider.
- Produces the 32-bit `freq_in` value (Hz) that the divider converts into the audible square wave.
- Two note sources:
  - Manual: selected by a 3-bit key code.
  - Auto-scan: steps through the 8-note Do–Do' scale at a fixed dwell time.
- Provides mute, a note-change strobe and a current-index output for display logic.

---
 rtl/tone_pkg.sv | 35 +++
 rtl/dwell_timer.sv | 41 ++++
 rtl/tone_sequencer.sv | 147 ++++++++++++++
 tb/tb_tone_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tone_pkg
//  Description : Shared types and constants for the tone sequencer: note
//                names, the Do..Do' frequency table (Hz) and the sequencer
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package tone_pkg;

    typedef enum logic [2:0] {
        DO    = 3'd0,
        RE    = 3'd1,
        MI    = 3'd2,
        FA    = 3'd3,
        SO    = 3'd4,
        LA    = 3'd5,
        SI    = 3'd6,
        DO_HI = 3'd7
    } note_t;

    // Packed so that NOTE_FREQ[i] selects entry i; element 7 is leftmost.
    localparam logic [7:0][31:0] NOTE_FREQ = {
        32'd1046, 32'd987, 32'd880, 32'd783,
        32'd698,  32'd659, 32'd587, 32'd523
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        AUTO   = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dwell_timer
//  Description : Counts 0 .. DWELL_CYCLES-1 while enabled and raises tick for
//                one cycle at the terminal count, then wraps to 0.
//  Ports       : in_clk  - clock (rising edge)
//                rst_n   - asynchronous active-low reset
//                clr     - synchronous clear, wins over en
//                en      - count enable
//                tick    - terminal-count pulse (combinational from count)
//  Revision    : 1.0 - initial release
// ============================================================================
module dwell_timer #(
    parameter int DWELL_CYCLES = 25_000_000
) (
    input  logic in_clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int                 c_cnt_w = $clog2(DWELL_CYCLES);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DWELL_CYCLES - 1);

    logic [c_cnt_w-1:0] r_cnt;

    assign tick = en && (r_cnt == c_last);

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tone_sequencer
//  Description : Selects the note frequency fed to the tone divider. Manual
//                mode follows note_sel; auto mode scans the 8-note scale with
//                a fixed dwell per note. All outputs are registered.
//  Ports       : in_clk, rst_n (async, active-low)
//                play, auto_en, dir, note_sel[2:0]   - controls
//                freq_out[31:0]  - Hz, 0 when muted
//                note_idx[2:0]   - index currently sounding
//                note_valid      - freq_out non-zero
//                note_strobe     - pulse on a new non-zero freq_out
//  Config      : TONE_SEQ_PINGPONG_EN - auto scan bounces at 0/7 instead of
//                wrapping; scan direction latched from dir on AUTO entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tone_sequencer #(
    parameter int DWELL_CYCLES = 25_000_000
) (
    input  logic        in_clk,
    input  logic        rst_n,
    input  logic        play,
    input  logic        auto_en,
    input  logic        dir,
    input  logic [2:0]  note_sel,
    output logic [31:0] freq_out,
    output logic [2:0]  note_idx,
    output logic        note_valid,
    output logic        note_strobe
);
    import tone_pkg::*;

    seq_state_t  r_state;
    seq_state_t  w_state_nxt;
    logic        w_auto_entry;
    logic        w_en;
    logic        w_tick;
    logic [2:0]  w_step_idx;
    logic [2:0]  w_idx_nxt;
    logic [31:0] w_freq_nxt;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (play) w_state_nxt = auto_en ? AUTO : MANUAL;
            MANUAL:  if (!play) w_state_nxt = IDLE;
                     else if (auto_en) w_state_nxt = AUTO;
            AUTO:    if (!play) w_state_nxt = IDLE;
                     else if (!auto_en) w_state_nxt = MANUAL;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Dwell runs only while staying in AUTO; any other cycle (including
    // entry and a simultaneous mute) holds it at zero, so a mute on the
    // terminal cycle can never step the index.
    assign w_auto_entry = (w_state_nxt == AUTO) && (r_state != AUTO);
    assign w_en         = (w_state_nxt == AUTO) && (r_state == AUTO);

    dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_dwell_timer (
        .in_clk(in_clk),
        .rst_n (rst_n),
        .clr   (!w_en),
        .en    (w_en),
        .tick  (w_tick)
    );

    // ---------------------------------------------------------- stepping
`ifdef TONE_SEQ_PINGPONG_EN
    logic r_dir_dn;
    logic w_dir_flip;

    always_comb begin
        w_step_idx = note_idx;
        w_dir_flip = 1'b0;
        if (!r_dir_dn) begin
            if (note_idx == 3'd7) begin
                w_step_idx = 3'd6;
                w_dir_flip = 1'b1;
            end else begin
                w_step_idx = note_idx + 3'd1;
            end
        end else begin
            if (note_idx == 3'd0) begin
                w_step_idx = 3'd1;
                w_dir_flip = 1'b1;
            end else begin
                w_step_idx = note_idx - 3'd1;
            end
        end
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir_dn <= 1'b0;
        end else if (w_auto_entry) begin
            r_dir_dn <= dir;
        end else if (w_en && w_tick && w_dir_flip) begin
            r_dir_dn <= ~r_dir_dn;
        end
    end
`else
    // 3-bit arithmetic gives the 7->0 / 0->7 wrap for free.
    always_comb begin
        w_step_idx = dir ? (note_idx - 3'd1) : (note_idx + 3'd1);
    end
`endif

    // ------------------------------------------------------ index / freq
    always_comb begin
        w_idx_nxt = note_idx;
        case (w_state_nxt)
            MANUAL: w_idx_nxt = note_sel;
            AUTO: begin
                if (w_auto_entry)  w_idx_nxt = note_sel;
                else if (w_tick)   w_idx_nxt = w_step_idx;
            end
            default: w_idx_nxt = note_idx;
        endcase
    end

    assign w_freq_nxt = (w_state_nxt == IDLE) ? 32'd0 : NOTE_FREQ[w_idx_nxt];

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            note_idx    <= 3'd0;
            freq_out    <= 32'd0;
            note_valid  <= 1'b0;
            note_strobe <= 1'b0;
        end else begin
            note_idx    <= w_idx_nxt;
            freq_out    <= w_freq_nxt;
            note_valid  <= (w_state_nxt != IDLE);
            note_strobe <= (w_freq_nxt != 32'd0) && (w_freq_nxt != freq_out);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tone_sequencer
//  Description : Self-checking bench for tone_sequencer (DWELL_CYCLES = 4).
//                A reference model predicts each cycle's outputs into a
//                scoreboard queue; directed scenarios add literal checks.
//                Honours TONE_SEQ_PINGPONG_EN for the expected scan order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_sequencer;

    localparam int DW = 4;

    logic        in_clk;
    logic        rst_n;
    logic        play;
    logic        auto_en;
    logic        dir;
    logic [2:0]  note_sel;
    logic [31:0] freq_out;
    logic [2:0]  note_idx;
    logic        note_valid;
    logic        note_strobe;

    tone_sequencer #(
        .DWELL_CYCLES(DW)
    ) dut (
        .in_clk     (in_clk),
        .rst_n      (rst_n),
        .play       (play),
        .auto_en    (auto_en),
        .dir        (dir),
        .note_sel   (note_sel),
        .freq_out   (freq_out),
        .note_idx   (note_idx),
        .note_valid (note_valid),
        .note_strobe(note_strobe)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic [31:0] f;
        logic [2:0]  i;
        logic        v;
        logic        s;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: mode 0 idle, 1 manual, 2 auto; m_left = cycles of
    // the current auto note still to run.
    int          m_mode;
    logic [2:0]  m_idx;
    int          m_left;
    logic        m_down;
    logic [31:0] m_freq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] freq_of(input logic [2:0] i);
        case (i)
            3'd0: return 32'd523;
            3'd1: return 32'd587;
            3'd2: return 32'd659;
            3'd3: return 32'd698;
            3'd4: return 32'd783;
            3'd5: return 32'd880;
            3'd6: return 32'd987;
            default: return 32'd1046;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_idx  = 3'd0;
        m_left = DW;
        m_down = 1'b0;
        m_freq = 32'd0;
    endtask

    task automatic model_advance(input logic d);
`ifdef TONE_SEQ_PINGPONG_EN
        if (!m_down) begin
            if (m_idx == 3'd7) begin m_idx = 3'd6; m_down = 1'b1; end
            else m_idx = m_idx + 3'd1;
        end else begin
            if (m_idx == 3'd0) begin m_idx = 3'd1; m_down = 1'b0; end
            else m_idx = m_idx - 3'd1;
        end
`else
        if (d) m_idx = m_idx - 3'd1;
        else   m_idx = m_idx + 3'd1;
`endif
    endtask

    task automatic cyc(input logic p, input logic a, input logic d, input logic [2:0] s);
        exp_t        e;
        logic [31:0] prev;
        play = p; auto_en = a; dir = d; note_sel = s;
        prev = m_freq;
        if (!p) begin
            m_mode = 0;
        end else if (a) begin
            if (m_mode != 2) begin
                m_mode = 2; m_idx = s; m_left = DW; m_down = d;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    model_advance(d);
                    m_left = DW;
                end
            end
        end else begin
            m_mode = 1; m_idx = s;
        end
        m_freq = (m_mode == 0) ? 32'd0 : freq_of(m_idx);
        e.f = m_freq;
        e.i = m_idx;
        e.v = (m_mode != 0);
        e.s = (m_freq != 32'd0) && (m_freq != prev);
        sb.push_back(e);
        @(posedge in_clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("sb_freq",   freq_out,    e.f);
            check("sb_idx",    note_idx,    e.i);
            check("sb_valid",  note_valid,  e.v);
            check("sb_strobe", note_strobe, e.s);
        end
    endtask

    initial begin
        logic [31:0] third;
        rst_n = 1'b0; play = 1'b0; auto_en = 1'b0; dir = 1'b0; note_sel = 3'd0;
        model_reset();
        repeat (2) @(posedge in_clk);
        #1;
        check("rst_freq",   freq_out,    32'd0);
        check("rst_idx",    note_idx,    32'd0);
        check("rst_valid",  note_valid,  32'd0);
        check("rst_strobe", note_strobe, 32'd0);
        @(negedge in_clk);
        rst_n = 1'b1;

        // Manual start on Do
        cyc(1, 0, 0, 3'd0);
        check("s1_freq",   freq_out,    32'd523);
        check("s1_strobe", note_strobe, 32'd1);
        check("s1_valid",  note_valid,  32'd1);
        cyc(1, 0, 0, 3'd0);
        check("s1_strobe_once", note_strobe, 32'd0);

        // Manual 2 -> 5, then rewrite 5
        cyc(1, 0, 0, 3'd2);
        check("s2_mi", freq_out, 32'd659);
        cyc(1, 0, 0, 3'd5);
        check("s2_la", freq_out, 32'd880);
        check("s2_la_strobe", note_strobe, 32'd1);
        cyc(1, 0, 0, 3'd5);
        check("s2_same_nostrobe", note_strobe, 32'd0);

        // Auto up from 6; note_sel wiggling is ignored
`ifdef TONE_SEQ_PINGPONG_EN
        third = 32'd987;
`else
        third = 32'd523;
`endif
        for (int k = 0; k < 12; k++) begin
            cyc(1, 1, 0, (k == 0) ? 3'd6 : 3'($urandom_range(0, 7)));
            check("s3_seq", freq_out, (k < 4) ? 32'd987 : (k < 8) ? 32'd1046 : third);
        end
        cyc(0, 0, 0, 3'd0);
        check("s3_mute", freq_out, 32'd0);

        // Auto down from 0
        for (int k = 0; k < 5; k++) begin
            cyc(1, 1, 1, 3'd0);
        end
`ifdef TONE_SEQ_PINGPONG_EN
        check("s4_step", freq_out, 32'd587);
`else
        check("s4_step", freq_out, 32'd1046);
`endif
        cyc(0, 0, 0, 3'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 1, 1, 3'd0);
        end
        // Terminal cycle: mute wins, index does not step
        cyc(0, 1, 1, 3'd0);
        check("s4_mute_freq", freq_out, 32'd0);
        check("s4_mute_idx",  note_idx, 32'd0);

        // Async reset mid-dwell at index 3
        cyc(1, 1, 0, 3'd3);
        cyc(1, 1, 0, 3'd3);
        check("s5_pre", freq_out, 32'd698);
        #2;
        rst_n = 1'b0;
        #1;
        check("s5_rst_freq",  freq_out,   32'd0);
        check("s5_rst_idx",   note_idx,   32'd0);
        check("s5_rst_valid", note_valid, 32'd0);
        model_reset();
        @(negedge in_clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc(1, 1, 0, 3'd5);
            check("s5_dwell", freq_out, (k < 4) ? 32'd880 : 32'd987);
        end

        // auto_en 1 -> 0 -> 1 mid-dwell restarts a full dwell
        cyc(1, 1, 0, 3'd1);
        cyc(1, 0, 0, 3'd2);
        check("s6_manual", freq_out, 32'd659);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 1, 0, 3'd4);
            check("s6_dwell", freq_out, (k < 4) ? 32'd783 : 32'd880);
        end

        // Mid-dwell direction change and general random traffic
        cyc(1, 1, 0, 3'd0);
        cyc(1, 1, 1, 3'd0);
        cyc(1, 1, 1, 3'd0);
        cyc(1, 1, 1, 3'd0);
        for (int k = 0; k < 120; k++) begin
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
